// File: rtl/scsi_handshake_ctrl.sv
// One-byte SCSI REQ/ACK transfer sequencer between the 1MHz-bus host registers and the target bus.
// Optional host interrupt output enabled by defining BEEBSCSI_IRQ_EN.
module scsi_handshake_ctrl #(
   parameter int ACK_SETUP = 2,
   parameter int DATA_HOLD = 2,
   parameter int TIMEOUT   = 1024
) (
   input  logic       clock,
   input  logic       nReset,
   input  logic       nREQ,
   input  logic       IO,
   input  logic [7:0] scsi_db_in,
   input  logic       host_rd_data,
   input  logic       host_wr_data,
   input  logic [7:0] host_wr_value,
   input  logic       clear_status,
   input  logic       irq_enable,
   output logic [7:0] host_db_out,
   output logic [7:0] scsi_db_out,
   output logic       nOE_scsi,
   output logic       nACK,
   output logic       req_pending,
   output logic       dir_in,
   output logic       busy,
   output logic       timeout_flag,
   output logic       nIRQ
);

   typedef enum logic [2:0] {IDLE, WAIT_HOST, SETUP, ACK_ASSERT, HOLD} stateT;

   stateT       state;
   logic [7:0]  dataReg;
   logic [15:0] cnt;

   assign host_db_out = dataReg;
   assign scsi_db_out = dataReg;
   assign busy        = (state != IDLE);

   // Counters are loaded with N and the transition fires when they read 1, giving exactly N cycles.
   always_ff @(posedge clock or negedge nReset) begin
      if (!nReset) begin
         state        <= IDLE;
         dataReg      <= 8'h00;
         cnt          <= 16'd0;
         nOE_scsi     <= 1'b1;
         nACK         <= 1'b1;
         req_pending  <= 1'b0;
         dir_in       <= 1'b0;
         timeout_flag <= 1'b0;
      end else begin
         // NOTE: non-blocking assignments, so a later timeout set overrides the clear in the same cycle.
         if (clear_status)
            timeout_flag <= 1'b0;
         case (state)
            IDLE: begin
               if (!nREQ) begin
                  dir_in      <= IO;
                  req_pending <= 1'b1;
                  if (IO)
                     dataReg <= scsi_db_in;
                  state <= WAIT_HOST;
               end
            end
            WAIT_HOST: begin
               if (dir_in) begin
                  if (host_rd_data) begin
                     nACK        <= 1'b0;
                     req_pending <= 1'b0;
                     cnt         <= 16'(TIMEOUT);
                     state       <= ACK_ASSERT;
                  end
               end else if (host_wr_data) begin
                  dataReg  <= host_wr_value;
                  nOE_scsi <= 1'b0;
                  cnt      <= 16'(ACK_SETUP);
                  state    <= SETUP;
               end
            end
            SETUP: begin
               if (cnt == 16'd1) begin
                  nACK        <= 1'b0;
                  req_pending <= 1'b0;
                  cnt         <= 16'(TIMEOUT);
                  state       <= ACK_ASSERT;
               end else begin
                  cnt <= cnt - 16'd1;
               end
            end
            ACK_ASSERT: begin
               if (nREQ || cnt == 16'd1) begin
                  nACK <= 1'b1;
                  if (!nREQ)
                     timeout_flag <= 1'b1;
                  if (dir_in) begin
                     state <= IDLE;
                  end else begin
                     cnt   <= 16'(DATA_HOLD);
                     state <= HOLD;
                  end
               end else begin
                  cnt <= cnt - 16'd1;
               end
            end
            HOLD: begin
               if (cnt == 16'd1) begin
                  nOE_scsi <= 1'b1;
                  state    <= IDLE;
               end else begin
                  cnt <= cnt - 16'd1;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

`ifdef BEEBSCSI_IRQ_EN
   always_ff @(posedge clock or negedge nReset) begin
      if (!nReset)
         nIRQ <= 1'b1;
      else
         nIRQ <= ~(req_pending & irq_enable);
   end
`else
   logic unusedIrqEnable;
   assign unusedIrqEnable = irq_enable;
   assign nIRQ            = 1'b1;
`endif

endmodule

// File: tb/tb_scsi_handshake_ctrl.sv
// Directed self-checking bench for scsi_handshake_ctrl (ACK_SETUP=2, DATA_HOLD=2, TIMEOUT=16).
module tb_scsi_handshake_ctrl;

   logic       clock = 1'b0;
   logic       nReset;
   logic       nREQ;
   logic       IO;
   logic [7:0] scsi_db_in;
   logic       host_rd_data;
   logic       host_wr_data;
   logic [7:0] host_wr_value;
   logic       clear_status;
   logic       irq_enable;
   logic [7:0] host_db_out;
   logic [7:0] scsi_db_out;
   logic       nOE_scsi;
   logic       nACK;
   logic       req_pending;
   logic       dir_in;
   logic       busy;
   logic       timeout_flag;
   logic       nIRQ;

   int nCompared   = 0;
   int nMismatched = 0;

   scsi_handshake_ctrl #(.ACK_SETUP(2), .DATA_HOLD(2), .TIMEOUT(16)) dut (
      .clock(clock), .nReset(nReset), .nREQ(nREQ), .IO(IO), .scsi_db_in(scsi_db_in),
      .host_rd_data(host_rd_data), .host_wr_data(host_wr_data), .host_wr_value(host_wr_value),
      .clear_status(clear_status), .irq_enable(irq_enable), .host_db_out(host_db_out),
      .scsi_db_out(scsi_db_out), .nOE_scsi(nOE_scsi), .nACK(nACK), .req_pending(req_pending),
      .dir_in(dir_in), .busy(busy), .timeout_flag(timeout_flag), .nIRQ(nIRQ)
   );

   always #5 clock = ~clock;

   task automatic check(input string tag, input logic [15:0] observed, input logic [15:0] expected);
      nCompared++;
      if (observed !== expected) begin
         nMismatched++;
         $display("FAIL %s: observed 0x%0h, expected 0x%0h at %0t", tag, observed, expected, $time);
      end
   endtask

   // Advance one rising edge and settle just after it.
   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   initial begin
      nReset = 1'b0; nREQ = 1'b1; IO = 1'b0; scsi_db_in = 8'h00;
      host_rd_data = 1'b0; host_wr_data = 1'b0; host_wr_value = 8'h00;
      clear_status = 1'b0; irq_enable = 1'b1;
      #22;
      check("rst_nACK", 16'(nACK), 16'd1);
      check("rst_nOE", 16'(nOE_scsi), 16'd1);
      check("rst_req_pending", 16'(req_pending), 16'd0);
      check("rst_dir_in", 16'(dir_in), 16'd0);
      check("rst_busy", 16'(busy), 16'd0);
      check("rst_timeout", 16'(timeout_flag), 16'd0);
      check("rst_nIRQ", 16'(nIRQ), 16'd1);
      check("rst_data", 16'(host_db_out), 16'h00);
      nReset = 1'b1;
      tick();

      // Read transfer with a wrong-direction strobe and an IO change while waiting.
      IO = 1'b1; scsi_db_in = 8'hA5; nREQ = 1'b0;
      tick();
      check("rd_data", 16'(host_db_out), 16'hA5);
      check("rd_req_pending", 16'(req_pending), 16'd1);
      check("rd_dir_in", 16'(dir_in), 16'd1);
      check("rd_busy", 16'(busy), 16'd1);
      check("rd_nIRQ_same_edge", 16'(nIRQ), 16'd1);
      host_wr_data = 1'b1; host_wr_value = 8'hFF; IO = 1'b0; scsi_db_in = 8'h11;
      tick();
      host_wr_data = 1'b0;
`ifdef BEEBSCSI_IRQ_EN
      check("rd_nIRQ", 16'(nIRQ), 16'd0);
`else
      check("rd_nIRQ", 16'(nIRQ), 16'd1);
`endif
      check("wrongdir_data", 16'(host_db_out), 16'hA5);
      check("wrongdir_nACK", 16'(nACK), 16'd1);
      check("wrongdir_nOE", 16'(nOE_scsi), 16'd1);
      check("wrongdir_pending", 16'(req_pending), 16'd1);
      check("wrongdir_dir_in", 16'(dir_in), 16'd1);
      host_rd_data = 1'b1;
      tick();
      host_rd_data = 1'b0;
      check("rd_nACK_low", 16'(nACK), 16'd0);
      check("rd_pending_clr", 16'(req_pending), 16'd0);
      tick();
      check("rd_nACK_held", 16'(nACK), 16'd0);
      nREQ = 1'b1;
      tick();
      check("rd_nACK_high", 16'(nACK), 16'd1);
      check("rd_busy_done", 16'(busy), 16'd0);
      check("rd_no_timeout", 16'(timeout_flag), 16'd0);
      check("rd_nIRQ_idle", 16'(nIRQ), 16'd1);

      // Write transfer; both strobes together, only the write acts.
      IO = 1'b0; nREQ = 1'b0;
      tick();
      check("wr_dir_in", 16'(dir_in), 16'd0);
      check("wr_pending", 16'(req_pending), 16'd1);
      host_wr_data = 1'b1; host_rd_data = 1'b1; host_wr_value = 8'h3C;
      tick();
      host_wr_data = 1'b0; host_rd_data = 1'b0;
      check("wr_scsi_db", 16'(scsi_db_out), 16'h3C);
      check("wr_nOE_low", 16'(nOE_scsi), 16'd0);
      check("wr_nACK_W", 16'(nACK), 16'd1);
      tick();
      check("wr_nACK_W1", 16'(nACK), 16'd1);
      tick();
      check("wr_nACK_W2", 16'(nACK), 16'd0);
      check("wr_pending_clr", 16'(req_pending), 16'd0);
      nREQ = 1'b1;
      tick();
      check("wr_nACK_high", 16'(nACK), 16'd1);
      check("wr_nOE_K", 16'(nOE_scsi), 16'd0);
      check("wr_busy_hold", 16'(busy), 16'd1);
      tick();
      check("wr_nOE_K1", 16'(nOE_scsi), 16'd0);
      tick();
      check("wr_nOE_K2", 16'(nOE_scsi), 16'd1);
      check("wr_busy_done", 16'(busy), 16'd0);

      // Timeout: nREQ never rises during a read ACK.
      IO = 1'b1; scsi_db_in = 8'h5A; nREQ = 1'b0;
      tick();
      host_rd_data = 1'b1;
      tick();
      host_rd_data = 1'b0;
      check("to_nACK_A", 16'(nACK), 16'd0);
      for (int i = 0; i < 15; i++) tick();
      check("to_nACK_A15", 16'(nACK), 16'd0);
      check("to_flag_A15", 16'(timeout_flag), 16'd0);
      tick();
      check("to_nACK_A16", 16'(nACK), 16'd1);
      check("to_flag_set", 16'(timeout_flag), 16'd1);
      nREQ = 1'b1;
      tick();
      check("to_flag_sticky", 16'(timeout_flag), 16'd1);
      clear_status = 1'b1;
      tick();
      clear_status = 1'b0;
      check("to_flag_clr", 16'(timeout_flag), 16'd0);

      // Asynchronous reset in the middle of a write ACK.
      IO = 1'b0; nREQ = 1'b0;
      tick();
      host_wr_data = 1'b1; host_wr_value = 8'hC3;
      tick();
      host_wr_data = 1'b0;
      tick();
      tick();
      check("mid_nACK_low", 16'(nACK), 16'd0);
      check("mid_nOE_low", 16'(nOE_scsi), 16'd0);
      #2;
      nReset = 1'b0;
      #1;
      check("mid_rst_nACK", 16'(nACK), 16'd1);
      check("mid_rst_nOE", 16'(nOE_scsi), 16'd1);
      check("mid_rst_pending", 16'(req_pending), 16'd0);
      check("mid_rst_busy", 16'(busy), 16'd0);
      check("mid_rst_data", 16'(host_db_out), 16'h00);
      nREQ = 1'b1;
      #3;
      nReset = 1'b1;
      tick();
      check("post_rst_idle", 16'(busy), 16'd0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
      $finish;
   end

endmodule

// File: doc/scsi_handshake_ctrl.md
# scsi_handshake_ctrl

Sequences one-byte SCSI REQ/ACK data transfers between the BBC Micro host interface and the emulated SCSI target bus.
- Latches target bytes for the host to read, or host bytes for the target, then runs the ACK handshake.
- Drives the active-low output enable of the inverting 74240-style buffer that places host data on the SCSI data lines.
- Sits between the 1MHz-bus register decode and the SCSI buffer logic in the CPLD.

## Interface
Parameters:
- ACK_SETUP, 2, cycles write data is driven before nACK falls (1..15)
- DATA_HOLD, 2, cycles write data stays driven after nACK rises (1..15)
- TIMEOUT, 1024, cycles allowed for nREQ to rise once nACK is low (1..65535)

Ports:
- clock  in  1  single system clock; all logic on its rising edge
- nReset  in  1  asynchronous, active-low reset
- nREQ  in  1  target REQ, active low, already synchronised to clock
- IO  in  1  target phase direction: 1 = target→host, 0 = host→target
- scsi_db_in  in  8  target data, true polarity
- host_rd_data  in  1  one-cycle pulse: host read of the data register
- host_wr_data  in  1  one-cycle pulse: host write of the data register
- host_wr_value  in  8  host write data
- clear_status  in  1  one-cycle pulse: clears timeout_flag
- irq_enable  in  1  host interrupt enable bit
- host_db_out  out  8  data register contents for host reads
- scsi_db_out  out  8  data to the inverting SCSI buffer, equal to the data register
- nOE_scsi  out  1  active-low enable for the SCSI-side inverting buffer
- nACK  out  1  SCSI ACK, active low
- req_pending  out  1  a byte awaits host action
- dir_in  out  1  IO value latched at REQ
- busy  out  1  state != IDLE
- timeout_flag  out  1  sticky handshake timeout
- nIRQ  out  1  active-low host interrupt

## Operation
Reset values (asynchronous):
- State IDLE; data register 0x00; counter 0.
- nOE_scsi=1, nACK=1, req_pending=0, dir_in=0, timeout_flag=0, nIRQ=1.

State machine:
- **IDLE**
  - Sample nREQ=0: latch IO into dir_in and set req_pending.
  - If IO=1, also load the data register from scsi_db_in.
  - Go to WAIT_HOST.
- **WAIT_HOST**
  - dir_in=1: host_rd_data → ACK_ASSERT.
  - dir_in=0: host_wr_data loads the register from host_wr_value, drives nOE_scsi=0 and loads the counter → SETUP.
  - The strobe for the other direction is ignored; if both strobes arrive together, only the matching one acts.
- **SETUP**: counts ACK_SETUP cycles with nOE_scsi=0, then → ACK_ASSERT.
- **ACK_ASSERT**
  - Entry drives nACK=0, clears req_pending and loads the timeout counter.
  - nREQ=1 sampled → nACK=1, then → HOLD if dir_in=0, or → IDLE if dir_in=1.
  - Counter expiry → set timeout_flag, nACK=1, then HOLD or IDLE by the same rule.
- **HOLD**: keeps nOE_scsi=0 for DATA_HOLD cycles, then nOE_scsi=1 → IDLE.

Other rules:
- IO changes after the latch are ignored until the next IDLE sample.
- Host strobes outside WAIT_HOST have no effect; host_db_out always shows the register.
- A new REQ is accepted only in IDLE. If nREQ is still low on return to IDLE, a new transfer starts.
- clear_status clears timeout_flag. If clear_status and a new timeout occur in the same cycle, the timeout wins.
- nReset asserted mid-handshake immediately releases nACK and nOE_scsi and discards the byte.

## Timing
- REQ recognised at edge N: req_pending=1 and the data register is valid after N.
- Read path: host_rd_data at edge R → nACK low after R. Register bytes pass through in 2 cycles minimum.
- Write path: host_wr_data at edge W → nOE_scsi low after W; nACK low after W+ACK_SETUP.
- nREQ high sampled at edge K → nACK high after K. For writes, nOE_scsi goes high after K+DATA_HOLD.
- Timeout: nACK is released after edge A+TIMEOUT, where A is the nACK-assert edge, if nREQ never rises.
- All outputs are registered; none has a combinational path from an input.

## Configuration
- Macro: BEEBSCSI_IRQ_EN.
- Defined: nIRQ = ~(req_pending & irq_enable), registered, one cycle after req_pending changes.
- Undefined: nIRQ is tied to 1; irq_enable is unused.
- Port list is the same in both cases.

## Test plan
- Reset mid-ACK (nACK=0, nOE_scsi=0) → both outputs go to 1 asynchronously; state IDLE; req_pending=0.
- Read transfer: IO=1, scsi_db_in=0xA5, nREQ falls → host_db_out=0xA5 and req_pending=1. Then host_rd_data → nACK low next cycle. Then nREQ rises → nACK high next cycle; busy=0.
- Write transfer: IO=0, nREQ falls, host_wr_data with 0x3C → scsi_db_out=0x3C and nOE_scsi=0. nACK falls 2 cycles later. After nREQ rises, nOE_scsi stays low 2 more cycles.
- Wrong-direction strobe: in a read phase, host_wr_data with 0xFF → register unchanged, no nACK, still WAIT_HOST.
- Timeout: TIMEOUT=16, nREQ held low → nACK released 16 cycles after asserting; timeout_flag=1 until clear_status.
- IRQ: with BEEBSCSI_IRQ_EN and irq_enable=1, nREQ falls → nIRQ=0 one cycle after req_pending. Without the macro, nIRQ stays 1.
